// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV immediate generator for the decode stage.
// Combinational decode of instr[31:7], then DEPTH register stages.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [24:0]     in_instr,
  input  logic [2:0]      in_type,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] imm_out,
  output logic            imm_valid,
  output logic            imm_illegal
);

  if (!(XLEN == 32 || XLEN == 64) || !(DEPTH == 1 || DEPTH == 2)) begin : g_bad_param
    $error("imm_gen_pipe: XLEN must be 32/64 and DEPTH 1/2");
  end

  typedef enum logic [2:0] {
    T_R  = 3'd0,
    T_I  = 3'd1,
    T_S  = 3'd2,
    T_B  = 3'd3,
    T_U  = 3'd4,
    T_J  = 3'd5,
    T_Z  = 3'd6,
    T_SH = 3'd7
  } imm_type_e;

  logic [XLEN-1:0] gen_imm;
  logic            gen_ill;

  // port bit p carries instr[p+7]
  always_comb begin
    gen_imm = '0;
    gen_ill = 1'b0;
    unique case (imm_type_e'(in_type))
      T_I: gen_imm = XLEN'($signed(in_instr[24:13]));
      T_S: gen_imm = XLEN'($signed({in_instr[24:18], in_instr[4:0]}));
      T_B: gen_imm = XLEN'($signed({in_instr[24], in_instr[0],
                                    in_instr[23:18], in_instr[4:1],
                                    1'b0}));
      T_U: gen_imm = XLEN'($signed({in_instr[24:5], 12'b0}));
      T_J: gen_imm = XLEN'($signed({in_instr[24], in_instr[12:5],
                                    in_instr[13], in_instr[23:14],
                                    1'b0}));
      T_Z: gen_imm = XLEN'(in_instr[12:8]);
      T_SH: begin
        if (XLEN == 32) begin
          gen_imm = XLEN'(in_instr[17:13]);
          gen_ill = in_instr[18];
        end else begin
          gen_imm = XLEN'(in_instr[18:13]);
        end
      end
      T_R: gen_ill = 1'b1;
      default: gen_ill = 1'b1;
    endcase
  end

  logic            v_q   [DEPTH];
  logic [XLEN-1:0] imm_q [DEPTH];
  logic            ill_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_q[k]   <= 1'b0;
        imm_q[k] <= '0;
        ill_q[k] <= 1'b0;
      end
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_q[k]   <= 1'b0;
        imm_q[k] <= '0;
        ill_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      v_q[0]   <= in_valid;
      imm_q[0] <= in_valid ? gen_imm : '0;
      ill_q[0] <= in_valid & gen_ill;
      for (int k = 1; k < DEPTH; k++) begin
        v_q[k]   <= v_q[k-1];
        imm_q[k] <= imm_q[k-1];
        ill_q[k] <= ill_q[k-1];
      end
    end
  end

  assign imm_out     = imm_q[DEPTH-1];
  assign imm_valid   = v_q[DEPTH-1];
  assign imm_illegal = ill_q[DEPTH-1];

endmodule
